div_16bit_sched: RTL

DIV_16BIT_SCHED -- requirements
Module: div_16bit_sched

---
 rtl/div_pkg.sv | 37 +++
 rtl/div_16bit_step.sv | 29 ++
 rtl/div_16bit_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the 16/8 round-robin divider.
// Imported by the scheduler and its single-step datapath.
package div_pkg;

  localparam int DIV_A_W   = 16;
  localparam int DIV_B_W   = 8;
  localparam int DIV_STEPS = 16;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_A_W-1:0] DIV_ZERO_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic               src;
    logic [DIV_A_W-1:0] a;
    logic [DIV_B_W-1:0] b;
  } div_req_t;

  typedef struct packed {
    logic               src;
    logic [DIV_A_W-1:0] quot;
    logic [DIV_A_W-1:0] odd;
    logic               dz;
  } div_res_t;

  function automatic logic [DIV_A_W:0] div_ext_b(
    input logic [DIV_B_W-1:0] b
  );
    return {{(DIV_A_W + 1 - DIV_B_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/div_16bit_step.sv
// One restoring shift-subtract step, MSB first.
// Partial remainder is {rem, a_bit}; subtract when it reaches b.
module div_16bit_step
  import div_pkg::*;
(
  input  logic [DIV_A_W-1:0] rem,
  input  logic               a_bit,
  input  logic [DIV_B_W-1:0] b,
  output logic [DIV_A_W-1:0] rem_next,
  output logic               q_bit
);

  logic [DIV_A_W:0] part;
  logic [DIV_A_W:0] ext_b;
  logic [DIV_A_W:0] diff;

  always_comb begin
    part  = {rem, a_bit};
    ext_b = div_ext_b(b);
    diff  = part - ext_b;
    q_bit = (part >= ext_b);
    if (q_bit) begin
      rem_next = diff[DIV_A_W-1:0];
    end else begin
      rem_next = part[DIV_A_W-1:0];
    end
  end

endmodule

// File: rtl/div_16bit_sched.sv
// Two-requester round-robin front end around an iterative
// restoring divider: one step per cycle, result held until taken.
module div_16bit_sched
  import div_pkg::*;
#(
  parameter logic [DIV_A_W-1:0] ZERO_Q = DIV_ZERO_Q
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [DIV_A_W-1:0] req0_a,
  input  logic [DIV_A_W-1:0] req1_a,
  input  logic [DIV_B_W-1:0] req0_b,
  input  logic [DIV_B_W-1:0] req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_src,
  output logic [DIV_A_W-1:0] res_quot,
  output logic [DIV_A_W-1:0] res_odd,
  output logic               res_dz,
  output logic               busy
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP =
    DIV_CNT_W'(DIV_STEPS - 1);

  div_state_t state_q;
  div_state_t state_d;

  logic               last_q;
  logic [DIV_A_W-1:0] a_q;
  logic [DIV_B_W-1:0] b_q;
  logic [DIV_A_W-1:0] rem_q;
  logic [DIV_A_W-1:0] quot_q;
  logic [DIV_CNT_W-1:0] step_q;
  logic               src_q;
  div_res_t           res_q;

  logic               gnt0;
  logic               gnt1;
  logic               acc;
  div_req_t           acc_req;
  logic               acc_dz;
  logic               step_last;
  logic [DIV_A_W-1:0] rem_nx;
  logic               q_bit;
  logic [DIV_A_W-1:0] quot_nx;

  div_16bit_step u_step (
    .rem      (rem_q),
    .a_bit    (a_q[DIV_A_W-1]),
    .b        (b_q),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  assign quot_nx   = {quot_q[DIV_A_W-2:0], q_bit};
  assign step_last = (step_q == LAST_STEP);

  assign acc         = gnt0 | gnt1;
  assign acc_req.src = gnt1;
  assign acc_req.a   = gnt1 ? req1_a : req0_a;
  assign acc_req.b   = gnt1 ? req1_b : req0_b;
  assign acc_dz      = (acc_req.b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = acc_dz ? DONE : CALC;
        end
      end
      CALC: begin
        if (step_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tie goes to whoever was not granted last.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    if (state_q == IDLE) begin
      unique case (1'b1)
        req0_valid && req1_valid: begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end
        req0_valid && !req1_valid: gnt0 = 1'b1;
        !req0_valid && req1_valid: gnt1 = 1'b1;
        default: ;
      endcase
    end
    req0_ready = gnt0;
    req1_ready = gnt1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      step_q <= '0;
      src_q  <= 1'b0;
      res_q  <= '0;
    end else if (acc) begin
      last_q <= acc_req.src;
      a_q    <= acc_req.a;
      b_q    <= acc_req.b;
      src_q  <= acc_req.src;
      rem_q  <= '0;
      quot_q <= '0;
      step_q <= '0;
      if (acc_dz) begin
        res_q.src  <= acc_req.src;
        res_q.quot <= ZERO_Q;
        res_q.odd  <= acc_req.a;
        res_q.dz   <= 1'b1;
      end
    end else if (state_q == CALC) begin
      a_q    <= {a_q[DIV_A_W-2:0], 1'b0};
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
      step_q <= step_q + 1'b1;
      if (step_last) begin
        res_q.src  <= src_q;
        res_q.quot <= quot_nx;
        res_q.odd  <= rem_nx;
        res_q.dz   <= 1'b0;
      end
    end
  end

  assign res_src  = res_q.src;
  assign res_quot = res_q.quot;
  assign res_odd  = res_q.odd;
  assign res_dz   = res_q.dz;

endmodule
